// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path: widths, write entry, one-hot decode.
// Used by the writeback queue and its output stage.
package regfile_pkg;

    localparam int REG_W    = 8;
    localparam int SEL_W    = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } wr_entry_t;

    function automatic logic [NUM_REGS-1:0] dec_onehot(input logic [SEL_W-1:0] sel);
        dec_onehot      = '0;
        dec_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Dual-push (ordered, port 0 older) single-pop FIFO; head is registered storage, pop is implicit when non-empty.
// A push with no free slot is dropped and flagged; a same-edge pop frees a slot for the pushes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   push0_vld,
    input  wr_entry_t              push0_dat,
    input  logic                   push1_vld,
    input  wr_entry_t              push1_dat,
    output logic                   pop_vld,
    output wr_entry_t              pop_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop,
    output logic [DEPTH-1:0]       ent_vld,
    output logic [SEL_W-1:0]       ent_sel [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    wr_entry_t mem_q [DEPTH];
    wr_entry_t mem_d [DEPTH];
    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      rd_ptr_q, rd_ptr_d;
    cnt_t      count_q, count_d;
    cnt_t      free;
    logic      acc0, acc1;

    always_comb begin
        pop_vld = cen && (count_q != '0);
        free    = cnt_t'(DEPTH) - count_q + cnt_t'(pop_vld);
        acc0    = cen && push0_vld && (free != '0);
        acc1    = cen && push1_vld && ((free - cnt_t'(acc0)) != '0);
        drop    = (cen && push0_vld && !acc0) || (cen && push1_vld && !acc1);

        mem_d = mem_q;
        if (acc0) mem_d[wr_ptr_q] = push0_dat;
        if (acc1) mem_d[wr_ptr_q + ptr_t'(acc0)] = push1_dat;

        wr_ptr_d = wr_ptr_q + ptr_t'(acc0) + ptr_t'(acc1);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_vld);
        count_d  = count_q + cnt_t'(acc0) + cnt_t'(acc1) - cnt_t'(pop_vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        ptr_t off;
        assign off        = ptr_t'(g) - rd_ptr_q;
        assign ent_vld[g] = cnt_t'(off) < count_q;
        assign ent_sel[g] = mem_q[g].sel;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Queues ALU/load results and issues one registered regfile write per enabled cycle (push-to-WE: 1 edge when idle).
// Ready drops when fewer than 2 slots are free; overflow is sticky. WB_R0_ZERO_EN discards writes to r0 at the input.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Cen,
    input  logic                MemValid,
    input  logic [SEL_W-1:0]    MemReg,
    input  logic [REG_W-1:0]    MemData,
    input  logic                AluValid,
    input  logic [SEL_W-1:0]    AluReg,
    input  logic [REG_W-1:0]    AluData,
    output logic                Ready,
    output logic                WE,
    output logic [SEL_W-1:0]    SelWR,
    output logic [REG_W-1:0]    Data,
    output logic [NUM_REGS-1:0] Busy,
    output logic                Overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             mem_vld, alu_vld;
    wr_entry_t        mem_ent, alu_ent;
    logic             pop_vld, drop;
    wr_entry_t        pop_dat;
    logic [CW-1:0]    fifo_cnt;
    logic [DEPTH-1:0] ent_vld;
    logic [SEL_W-1:0] ent_sel [DEPTH];

    logic             we_q, we_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [REG_W-1:0] data_q, data_d;
    logic             overflow_q, overflow_d;

`ifdef WB_R0_ZERO_EN
    assign mem_vld = MemValid && (MemReg != '0);
    assign alu_vld = AluValid && (AluReg != '0);
`else
    assign mem_vld = MemValid;
    assign alu_vld = AluValid;
`endif

    assign mem_ent = '{sel: MemReg, data: MemData};
    assign alu_ent = '{sel: AluReg, data: AluData};

    // Loads go on port 0 so they are queued ahead of same-cycle ALU results.
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (Clk),
        .rst       (Rst),
        .cen       (Cen),
        .push0_vld (mem_vld),
        .push0_dat (mem_ent),
        .push1_vld (alu_vld),
        .push1_dat (alu_ent),
        .pop_vld   (pop_vld),
        .pop_dat   (pop_dat),
        .count     (fifo_cnt),
        .drop      (drop),
        .ent_vld   (ent_vld),
        .ent_sel   (ent_sel)
    );

    always_comb begin
        we_d       = we_q;
        sel_d      = sel_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        if (Cen) begin
            we_d       = pop_vld;
            overflow_d = overflow_q || drop;
            if (pop_vld) begin
                sel_d  = pop_dat.sel;
                data_d = pop_dat.data;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q       <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        Busy = we_q ? dec_onehot(sel_q) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) Busy = Busy | dec_onehot(ent_sel[i]);
        end
`ifdef WB_R0_ZERO_EN
        Busy[0] = 1'b0;
`endif
    end

    assign Ready    = Cen && ((CW'(DEPTH) - fifo_cnt) >= CW'(2));
    assign WE       = we_q;
    assign SelWR    = sel_q;
    assign Data     = data_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes queued at stimulus time, checked by a WE monitor.
module tb_regfile_writeback;
    import regfile_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Cen = 1'b1;
    logic       MemValid = 1'b0;
    logic [2:0] MemReg = '0;
    logic [7:0] MemData = '0;
    logic       AluValid = 1'b0;
    logic [2:0] AluReg = '0;
    logic [7:0] AluData = '0;
    logic       Ready, WE, Overflow;
    logic [2:0] SelWR;
    logic [7:0] Data, Busy;

    regfile_writeback #(.DEPTH(4)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Cen      (Cen),
        .MemValid (MemValid),
        .MemReg   (MemReg),
        .MemData  (MemData),
        .AluValid (AluValid),
        .AluReg   (AluReg),
        .AluData  (AluData),
        .Ready    (Ready),
        .WE       (WE),
        .SelWR    (SelWR),
        .Data     (Data),
        .Busy     (Busy),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [10:0] exp_q [$];
    bit          en_edge = 1'b0;

    always @(posedge Clk) en_edge <= Cen && !Rst;

    // Each enabled, non-reset edge that leaves WE high is one new write.
    always @(negedge Clk) begin
        if (en_edge && WE) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write: unexpected sel=%0d data=0x%02h, want no write", SelWR, Data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if ({SelWR, Data} !== e) begin
                    n_err++;
                    $display("FAIL write: got sel=%0d data=0x%02h, want sel=%0d data=0x%02h",
                             SelWR, Data, e[10:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drive(input logic mv, input logic [2:0] mr, input logic [7:0] md,
                         input logic av, input logic [2:0] ar, input logic [7:0] ad);
        MemValid = mv; MemReg = mr; MemData = md;
        AluValid = av; AluReg = ar; AluData = ad;
    endtask

    initial begin
        // Reset then idle
        tick(2);
        Rst = 1'b0;
        chk("rst_we", WE, 0);
        chk("rst_sel", SelWR, 0);
        chk("rst_data", Data, 0);
        chk("rst_busy", Busy, 8'h00);
        chk("rst_ovf", Overflow, 0);
        chk("rst_ready", Ready, 1);

        // Single ALU write to r3
        drive(0, 0, 0, 1, 3'd3, 8'h5A);
        exp_q.push_back({3'd3, 8'h5A});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("alu_busy_k", Busy, 8'h08);
        tick();
        chk("alu_busy_k1", Busy, 8'h08);
        chk("alu_we_k1", WE, 1);
        tick();
        chk("alu_busy_k2", Busy, 8'h00);
        chk("alu_we_k2", WE, 0);

        // Simultaneous sources: load is older
        drive(1, 3'd1, 8'hA1, 1, 3'd2, 8'hB2);
        exp_q.push_back({3'd1, 8'hA1});
        exp_q.push_back({3'd2, 8'hB2});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("sim_busy_k", Busy, 8'h06);
        tick();
        chk("sim_busy_k1", Busy, 8'h06);
        tick();
        chk("sim_busy_k2", Busy, 8'h04);
        tick();
        chk("sim_busy_k3", Busy, 8'h00);

        // Cen stall with one write out and one queued
        drive(1, 3'd4, 8'h44, 1, 3'd5, 8'h55);
        exp_q.push_back({3'd4, 8'h44});
        exp_q.push_back({3'd5, 8'h55});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        Cen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", Ready, 0);
            chk("stall_we", WE, 1);
            chk("stall_sel", SelWR, 4);
            chk("stall_data", Data, 8'h44);
            chk("stall_busy", Busy, 8'h30);
        end
        Cen = 1'b1;
        tick();
        chk("resume_busy", Busy, 8'h20);
        chk("resume_sel", SelWR, 5);
        chk("resume_data", Data, 8'h55);
        tick();
        chk("resume_idle_busy", Busy, 8'h00);

        // Register 0 write
        drive(0, 0, 0, 1, 3'd0, 8'hFF);
`ifdef WB_R0_ZERO_EN
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("r0_busy_k", Busy, 8'h00);
        tick();
        chk("r0_we_k1", WE, 0);
        chk("r0_busy_k1", Busy, 8'h00);
        chk("r0_ovf", Overflow, 0);
`else
        exp_q.push_back({3'd0, 8'hFF});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("r0_busy_k", Busy, 8'h01);
        tick();
        chk("r0_we_k1", WE, 1);
        tick();
        chk("r0_busy_k2", Busy, 8'h00);
`endif

        // Fill and overflow: both sources for 4 cycles; A3 is the one dropped
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'(i + 1), 8'(8'h80 + i), 1, 3'(i + 4), 8'(8'hC0 + i));
            exp_q.push_back({3'(i + 1), 8'(8'h80 + i)});
            if (i != 3) exp_q.push_back({3'(i + 4), 8'(8'hC0 + i)});
            tick();
            if (i == 0) chk("fill_ready_1", Ready, 1);
            if (i == 1) chk("fill_ready_2", Ready, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("fill_ovf", Overflow, 1);
        chk("fill_busy", Busy, 8'h7C);
        tick(5);
        chk("drain_busy", Busy, 8'h00);
        chk("drain_ovf_sticky", Overflow, 1);
        chk("drain_ready", Ready, 1);

        // Reset mid-queue discards pending writes
        drive(1, 3'd6, 8'h66, 1, 3'd7, 8'h77);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("midq_busy", Busy, 8'hC0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("midq_we", WE, 0);
        chk("midq_busy_rst", Busy, 8'h00);
        chk("midq_ovf", Overflow, 0);
        tick(3);
        chk("midq_we_after", WE, 0);

        chk("pending_writes", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side sequencer for the CPU's 8×8-bit register file. It accepts result writes from two producers, the ALU and the memory load path, and queues them in a small FIFO. It then issues at most one write per enabled cycle on the register file's select/data/write-enable port. It also publishes a per-register busy mask so the decode stage can stall on registers with pending writes.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Cen  in  1  clock enable. When low, all state holds and inputs are ignored.
- MemValid  in  1  load result present this cycle.
- MemReg  in  3  load destination register.
- MemData  in  8  load result.
- AluValid  in  1  ALU result present this cycle.
- AluReg  in  3  ALU destination register.
- AluData  in  8  ALU result.
- Ready  out  1  Cen & (free slots ≥ 2). Combinational from registered count.
- WE  out  1  register file write enable (registered).
- SelWR  out  3  register file write select (registered).
- Data  out  8  register file write data (registered).
- Busy  out  8  bit i set while any queued entry, or the current output with WE=1, targets register i.
- Overflow  out  1  sticky; set when an accepted-cycle request was dropped for lack of space.

## Operation
- Reset values: FIFO empty, count=0, WE=0, SelWR=0, Data=0, Busy=0, Overflow=0. Ready=1 when Cen=1.
- Push happens on a rising edge with Cen=1, in the following order:
  - MemValid pushes first. Loads are older than same-cycle ALU results.
  - AluValid pushes second.
  - Each push consumes one slot if available.
  - A request with no slot is dropped and sets Overflow.
- Producers may assert Valid only in cycles where Ready=1. Ready is conservative: it uses the pre-pop count.
- Pop happens on a rising edge with Cen=1:
  - If the FIFO is non-empty before this edge, the head moves to {SelWR, Data} and WE=1.
  - Otherwise WE=0, and SelWR/Data hold their previous values.
- Push and pop in the same edge are legal: count_next = count + pushes − pop.
  - A full FIFO with a pop and two pushes accepts only one push. The Mem request wins; the Alu request is dropped and Overflow is set.
- When Cen=0: no push, no pop, outputs and Overflow hold, Ready=0.
- Busy is combinational from registered state: OR of decoded targets of valid FIFO entries, plus the decoded SelWR when WE=1.
- Same-register writes stay in FIFO order, so the last write wins in the register file.

## Timing
- A push at edge k into an empty FIFO appears on WE/SelWR/Data after edge k+1. The register file commits it at edge k+2.
- Throughput is one write per Cen cycle. Two producers pushing every cycle will fill the FIFO; Ready drops when free < 2.
- A Busy bit rises the cycle after the push edge and clears the cycle after the register file commits (edge k+2 for an uncontended entry).
- Rst overrides Cen. Reset mid-queue discards all pending entries with no further WE pulses.

## Configuration
- WB_R0_ZERO_EN defined:
  - Requests with target register 0 are discarded at the input. They are never queued, never set Busy[0], and never count toward Overflow.
  - Busy[0] is constant 0.
- WB_R0_ZERO_EN undefined: register 0 is written like any other register.

## Structure
- Shared package regfile_pkg holds:
  - constants REG_W=8, SEL_W=3, NUM_REGS=8;
  - the write-entry type {sel[2:0], data[7:0]};
  - the one-hot decode function used for Busy.
- One sub-module, wb_fifo: a synchronous FIFO with two push ports (ordered), one pop port, count, and a per-entry valid/target view for Busy.
- regfile_writeback instantiates wb_fifo and holds the output register, Overflow, and the Busy logic.

## Test plan
- Reset then idle: Rst high 2 cycles → WE=0, SelWR=0, Data=0, Busy=0x00, Overflow=0, Ready=1.
- Single ALU write: AluValid, AluReg=3, AluData=0x5A at edge k → after k+1, WE=1, SelWR=3, Data=0x5A; Busy=0x08 from k until after k+2, then 0x00.
- Simultaneous sources: MemReg=1/0xA1 and AluReg=2/0xB2 in the same cycle → consecutive writes (1,0xA1) then (2,0xB2); Busy=0x06 then 0x04 then 0x00.
- Fill and overflow: both sources every cycle, ignoring Ready → Ready falls when free<2, Alu entries are dropped first, Overflow latches 1 and stays 1 until Rst.
- Cen stall: queue 2 entries, drop Cen for 3 cycles → WE/SelWR/Data/Busy hold and Ready=0; on Cen=1, draining resumes in order.
- With WB_R0_ZERO_EN: AluReg=0/0xFF → no WE pulse and Busy[0] stays 0. Without the macro → a write (0, 0xFF) is issued.
